polyphase_output_serializer: RTL

- Downstream stage of the two-phase polyphase FIR. Consumes one (y_even, y_odd) output pair per FIR output event and re-interleaves the pair into a single full-rate sample stream: even first, then odd.
- Buffers pairs in a small FIFO so that sink back-pressure is absorbed.
- Applies an optional rounding right-shift with saturation, then drives a valid/ready stream in the clk_2f domain.

---
 rtl/polyphase_pkg.sv | 44 ++++
 rtl/polyphase_output_serializer_fifo.sv | 63 ++++++
 rtl/polyphase_output_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/polyphase_pkg.sv
// Shared types and scaling helper for the polyphase FIR output path.
// sat_round rounds half-up on an arithmetic right shift, then clamps to out_w signed bits.
package polyphase_pkg;

   localparam int unsigned SAMPLE_W   = 16;
   localparam int unsigned NUM_PHASES = 2;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] even;
      logic signed [SAMPLE_W-1:0] odd;
   } pair_t;

   typedef enum logic [1:0] {EMPTY, EVEN, ODD} ser_state_e;

   function automatic logic signed [SAMPLE_W-1:0] sat_round(
      input logic signed [SAMPLE_W-1:0] y,
      input int unsigned                shift,
      input int unsigned                out_w
   );
      logic signed [SAMPLE_W:0] ext;
      logic signed [SAMPLE_W:0] rnd;
      logic signed [SAMPLE_W:0] t;
      logic signed [SAMPLE_W:0] max_v;
      logic signed [SAMPLE_W:0] min_v;
      ext = {y[SAMPLE_W-1], y};
      rnd = '0;
      if (shift > 0) begin
         // One guard bit so the rounding add cannot wrap.
         rnd = (SAMPLE_W+1)'(1) <<< (shift - 1);
         t   = (ext + rnd) >>> shift;
      end else begin
         t = ext;
      end
      max_v = (SAMPLE_W+1)'((32'sd1 <<< (out_w - 1)) - 32'sd1);
      min_v = -max_v - (SAMPLE_W+1)'(1);
      if (t > max_v) begin
         t = max_v;
      end else if (t < min_v) begin
         t = min_v;
      end
      return t[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/polyphase_output_serializer_fifo.sv
// Single-clock FIFO of sample pairs; pointers wrap naturally, full/empty come from the level count.
module pair_fifo
   import polyphase_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  pair_t                    wdata_i,
   output pair_t                    rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   pair_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/polyphase_output_serializer.sv
// Re-interleaves (even, odd) FIR output pairs into one full-rate valid/ready stream,
// buffering pairs in a FIFO and scaling/saturating each pair as it is popped.
module polyphase_output_serializer
   import polyphase_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk_2f,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         y_even,
   input  logic [IN_W-1:0]         y_odd,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        y_out,
   output logic                    out_phase,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow,
   input  logic                    ovf_clr
);

   pair_t      wdata, head;
   logic       fifo_full, fifo_empty, pop, drop;
   ser_state_e state_q, state_d;

   logic [OUT_W-1:0]                y_out_q, y_out_d;
   logic [OUT_W-1:0]                odd_q, odd_d;
   logic [$clog2(NUM_PHASES)-1:0]   phase_q, phase_d;
   logic                            valid_q, valid_d;
   logic                            ovf_q, ovf_d;
   logic [OUT_W-1:0]                head_even_s, head_odd_s;

   assign wdata.even = SAMPLE_W'($signed(y_even));
   assign wdata.odd  = SAMPLE_W'($signed(y_odd));

   pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_2f),
      .rst_i   (rst),
      .push_i  (in_valid),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign drop     = in_valid && fifo_full;

   assign head_even_s = OUT_W'(sat_round(head.even, SHIFT, OUT_W));
   assign head_odd_s  = OUT_W'(sat_round(head.odd, SHIFT, OUT_W));

   always_comb begin
      state_d = state_q;
      y_out_d = y_out_q;
      odd_d   = odd_q;
      phase_d = phase_q;
      valid_d = valid_q;
      pop     = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = EVEN;
               valid_d = 1'b1;
               phase_d = 1'b0;
               y_out_d = head_even_s;
               odd_d   = head_odd_s;
            end
         end
         EVEN: begin
            if (out_ready) begin
               state_d = ODD;
               phase_d = 1'b1;
               y_out_d = odd_q;
            end
         end
         ODD: begin
            if (out_ready) begin
               if (!fifo_empty) begin
                  // Back-to-back: the next pair follows with no bubble.
                  pop     = 1'b1;
                  state_d = EVEN;
                  phase_d = 1'b0;
                  y_out_d = head_even_s;
                  odd_d   = head_odd_s;
               end else begin
                  state_d = EMPTY;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = EMPTY;
            valid_d = 1'b0;
         end
      endcase
   end

   // A drop in the same cycle as a clear still leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_2f or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         y_out_q <= '0;
         odd_q   <= '0;
         phase_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_out_q <= y_out_d;
         odd_q   <= odd_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = valid_q;
   assign y_out     = y_out_q;
   assign out_phase = phase_q;
   assign overflow  = ovf_q;

endmodule
